// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the SPI transaction scheduler (spi_sched).
package spi_sched_pkg;

    localparam int DLY_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_START = 3'd2,
        ST_XFER  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        DTB_8  = 2'b00,
        DTB_16 = 2'b01,
        DTB_24 = 2'b10,
        DTB_32 = 2'b11
    } dtb_t;

endpackage

// File: rtl/spi_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module spi_rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr_i) + i) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/spi_sched.sv
// Arbitrates NUM_REQ requesters onto one SPI core and sequences CS setup/hold/gap.
// Optional transfer watchdog enabled by defining SPI_SCHED_TIMEOUT_EN.
module spi_sched
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TMO_W   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [2*NUM_REQ-1:0]   dtb_i,
    input  logic [DLY_W-1:0]       setup_i,
    input  logic [DLY_W-1:0]       hold_i,
    input  logic [DLY_W-1:0]       gap_i,
    input  logic [TMO_W-1:0]       tmo_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic                   err_o,
    output logic [NUM_REQ-1:0]     nss_o,
    output logic                   core_st_o,
    output logic [1:0]             core_dtb_o,
    input  logic                   core_busy_i,
    output logic                   busy_o,
    output logic [2:0]             dbg_state_o
);

    localparam int IW = $clog2(NUM_REQ);

    state_t             state_q, state_d;
    logic [DLY_W-1:0]   cnt_q, cnt_d;
    logic [DLY_W-1:0]   hold_q, hold_d;
    logic [DLY_W-1:0]   gap_q, gap_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] nss_q, nss_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [1:0]         dtb_q, dtb_d;
    logic               seen_q, seen_d;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               tmo_hit;

    spi_rr_arb #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

`ifdef SPI_SCHED_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [TMO_W-1:0] wdt_q, wdt_d;
    logic [TMO_W-1:0] wdt_inc;

    // Fires during the XFER cycle whose ordinal equals the latched limit.
    assign wdt_inc = wdt_q + TMO_W'(1);
    assign tmo_hit = (state_q == ST_XFER) && (wdt_inc == tmo_q);
`else
    logic unused_tmo;
    assign unused_tmo = ^tmo_i;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        nss_d   = nss_q;
        done_d  = '0;
        dtb_d   = dtb_q;
        seen_d  = seen_q;
`ifdef SPI_SCHED_TIMEOUT_EN
        tmo_d   = tmo_q;
        wdt_d   = wdt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d = ST_SETUP;
                    gnt_d   = arb_gnt;
                    nss_d   = ~arb_gnt;
                    gidx_d  = arb_idx;
                    dtb_d   = dtb_i[{arb_idx, 1'b0} +: 2];
                    cnt_d   = setup_i;
                    hold_d  = hold_i;
                    gap_d   = gap_i;
`ifdef SPI_SCHED_TIMEOUT_EN
                    tmo_d   = tmo_i;
`endif
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) state_d = ST_START;
                else             cnt_d   = cnt_q - DLY_W'(1);
            end
            ST_START: begin
                state_d = ST_XFER;
                seen_d  = 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
                wdt_d   = '0;
`endif
            end
            ST_XFER: begin
                // Completion is the first busy-low cycle after busy was seen high.
                seen_d = seen_q | core_busy_i;
`ifdef SPI_SCHED_TIMEOUT_EN
                wdt_d  = wdt_inc;
`endif
                if (tmo_hit || (seen_q && !core_busy_i)) begin
                    state_d = ST_HOLD;
                    cnt_d   = hold_q;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    nss_d   = '1;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    ptr_d   = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);
                    cnt_d   = gap_q;
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - DLY_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            ptr_q   <= '0;
            gidx_q  <= '0;
            gnt_q   <= '0;
            nss_q   <= '1;
            done_q  <= '0;
            dtb_q   <= DTB_8;
            seen_q  <= 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
            tmo_q   <= '0;
            wdt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            nss_q   <= nss_d;
            done_q  <= done_d;
            dtb_q   <= dtb_d;
            seen_q  <= seen_d;
`ifdef SPI_SCHED_TIMEOUT_EN
            tmo_q   <= tmo_d;
            wdt_q   <= wdt_d;
`endif
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign err_o       = tmo_hit;
    assign nss_o       = nss_q;
    assign core_st_o   = (state_q == ST_START);
    assign core_dtb_o  = dtb_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_sched.sv
// Self-checking bench for spi_sched: cycle-level timeline model plus round-robin model.
module tb_spi_sched;
    import spi_sched_pkg::*;

    localparam int N  = 4;
    localparam int TW = 16;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_i;
    logic [2*N-1:0]  dtb_i;
    logic [3:0]      setup_i, hold_i, gap_i;
    logic [TW-1:0]   tmo_i;
    logic [N-1:0]    gnt_o, done_o, nss_o;
    logic            err_o, core_st_o, core_busy_i, busy_o;
    logic [1:0]      core_dtb_o;
    logic [2:0]      dbg_state_o;

    spi_sched #(.NUM_REQ(N), .TMO_W(TW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .dtb_i       (dtb_i),
        .setup_i     (setup_i),
        .hold_i      (hold_i),
        .gap_i       (gap_i),
        .tmo_i       (tmo_i),
        .gnt_o       (gnt_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .nss_o       (nss_o),
        .core_st_o   (core_st_o),
        .core_dtb_o  (core_dtb_o),
        .core_busy_i (core_busy_i),
        .busy_o      (busy_o),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;

    // Observed timeline of one transaction
    int o_t0, o_gnt_c, o_st_c, o_st_n, o_done_c, o_done_n, o_err_c, o_err_n;
    int o_nss_low, o_idle_c, o_setup_len, o_hold_len, o_gap_len;
    logic [N-1:0] o_gnt, o_done;
    logic [1:0]   o_dtb;
    bit o_overlap, o_hung, o_gnt_changed;

    typedef struct packed {
        int gnt_c;
        int st_c;
        int err_c;
        int done_c;
        int idle_c;
        int nss_low;
    } exp_t;

    function automatic int m_pick(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (m_ptr + i) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // Expected cycle numbers from the request cycle t0; busy rises d cycles after start for l cycles.
    function automatic exp_t m_txn(input int t0, input int s, input int h, input int g,
                                   input int d, input int l, input bit to, input int tmo);
        exp_t e;
        int hold_start;
        e.gnt_c = t0 + 1;
        e.st_c  = t0 + 2 + s;
        e.err_c = to ? e.st_c + tmo : -1;
        hold_start = to ? e.st_c + tmo + 1 : e.st_c + d + l + 1;
        e.done_c  = hold_start + h + 1;
        e.idle_c  = e.done_c + g + 1;
        e.nss_low = e.done_c - e.gnt_c;
        return e;
    endfunction

    task automatic observe_txn(input int d, input int l, input bit stuck, input bit drop);
        int c;
        o_t0 = cyc; o_gnt_c = -1; o_st_c = -1; o_st_n = 0; o_done_c = -1; o_done_n = 0;
        o_err_c = -1; o_err_n = 0; o_nss_low = 0; o_idle_c = -1;
        o_setup_len = 0; o_hold_len = 0; o_gap_len = 0;
        o_gnt = '0; o_done = '0; o_dtb = '0; o_overlap = 0; o_hung = 0; o_gnt_changed = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            c = cyc;
            if (o_gnt_c < 0 && gnt_o != '0) begin
                o_gnt_c = c; o_gnt = gnt_o; o_dtb = core_dtb_o;
                if (drop) begin
                    req_i = '0; setup_i = 4'($urandom); hold_i = 4'($urandom);
                    gap_i = 4'($urandom); dtb_i = 8'($urandom);
                end
            end
            if (core_st_o) begin
                if (o_st_c < 0) o_st_c = c;
                o_st_n++;
            end
            if (nss_o != '1) o_nss_low++;
            if ($countones(~nss_o) > 1) o_overlap = 1;
            if (done_o != '0) begin o_done_c = c; o_done = done_o; o_done_n++; end
            if (o_gnt_c >= 0 && o_done_c < 0 && gnt_o !== o_gnt) o_gnt_changed = 1;
            if (err_o) begin o_err_c = c; o_err_n++; end
            if (dbg_state_o == ST_SETUP) o_setup_len++;
            if (dbg_state_o == ST_HOLD)  o_hold_len++;
            if (dbg_state_o == ST_GAP)   o_gap_len++;
            if (o_st_c >= 0)
                core_busy_i = stuck ? (c >= o_st_c + d) : (c >= o_st_c + d && c < o_st_c + d + l);
            if (o_done_c >= 0 && !busy_o) begin
                o_idle_c = c; core_busy_i = 1'b0;
                return;
            end
        end
        o_hung = 1;
        core_busy_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; req_i = '0; dtb_i = '0; setup_i = '0; hold_i = '0; gap_i = '0;
        tmo_i = '1; core_busy_i = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (gnt_o !== '0) begin bad++; $display("FAIL reset_gnt: got %b exp 0000", gnt_o); end
        total++; if (nss_o !== '1) begin bad++; $display("FAIL reset_nss: got %b exp 1111", nss_o); end
        total++; if ({done_o, err_o, core_st_o, busy_o} !== '0) begin bad++;
            $display("FAIL reset_pulses: done=%b err=%b st=%b busy=%b exp all 0", done_o, err_o, core_st_o, busy_o); end
        total++; if (core_dtb_o !== 2'b00) begin bad++; $display("FAIL reset_dtb: got %b exp 00", core_dtb_o); end
        total++; if (dbg_state_o !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d exp %0d", dbg_state_o, ST_IDLE); end
        rst_i = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_contention;
        int ei;
        exp_t e;
        setup_i = 4'd1; hold_i = 4'd0; gap_i = 4'd1; dtb_i = 8'hE4;
        req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            ei = m_pick(4'b1111);
            observe_txn(1, 2, 1'b0, 1'b0);
            e = m_txn(o_t0, 1, 0, 1, 1, 2, 1'b0, 0);
            total++; if (o_gnt !== N'(1 << ei)) begin bad++; $display("FAIL contention_gnt%0d: got %b exp %b", k, o_gnt, N'(1 << ei)); end
            total++; if (o_gnt_c !== e.gnt_c || o_done_c !== e.done_c) begin bad++;
                $display("FAIL contention_timing%0d: gnt@%0d done@%0d exp gnt@%0d done@%0d", k, o_gnt_c, o_done_c, e.gnt_c, e.done_c); end
            total++; if (o_overlap || o_hung) begin bad++; $display("FAIL contention_nss%0d: overlap=%0d hung=%0d exp 0 0", k, o_overlap, o_hung); end
            m_ptr = (ei + 1) % N;
        end
        req_i = '0;
    endtask

    task automatic test_single;
        exp_t e;
        int ei;
        setup_i = 4'd2; hold_i = 4'd1; gap_i = 4'd3; dtb_i = 8'hFC;
        req_i = 4'b0001;
        ei = m_pick(4'b0001);
        observe_txn(1, 8, 1'b0, 1'b1);
        e = m_txn(o_t0, 2, 1, 3, 1, 8, 1'b0, 0);
        total++; if (o_gnt !== N'(1 << ei) || o_gnt_c !== e.gnt_c) begin bad++;
            $display("FAIL single_gnt: got %b@%0d exp %b@%0d", o_gnt, o_gnt_c, N'(1 << ei), e.gnt_c); end
        total++; if (o_dtb !== 2'b00) begin bad++; $display("FAIL single_dtb: got %b exp 00", o_dtb); end
        total++; if (o_st_c !== e.st_c || o_st_n !== 1) begin bad++;
            $display("FAIL single_st: got @%0d x%0d exp @%0d x1", o_st_c, o_st_n, e.st_c); end
        total++; if (o_nss_low !== e.nss_low) begin bad++; $display("FAIL single_nss_low: got %0d exp %0d", o_nss_low, e.nss_low); end
        total++; if (o_done !== N'(1 << ei) || o_done_n !== 1 || o_done_c !== e.done_c) begin bad++;
            $display("FAIL single_done: got %b x%0d @%0d exp %b x1 @%0d", o_done, o_done_n, o_done_c, N'(1 << ei), e.done_c); end
        total++; if (o_idle_c !== e.idle_c || o_gap_len !== 4) begin bad++;
            $display("FAIL single_idle: got @%0d gap=%0d exp @%0d gap=4", o_idle_c, o_gap_len, e.idle_c); end
        total++; if (o_gnt_changed) begin bad++; $display("FAIL single_gnt_held: got changed exp held"); end
        m_ptr = (ei + 1) % N;
    endtask

    task automatic test_drop;
        exp_t e;
        setup_i = 4'd3; hold_i = 4'd2; gap_i = 4'd1; dtb_i = 8'h20;
        req_i = 4'b0100;
        observe_txn(2, 3, 1'b0, 1'b1);
        e = m_txn(o_t0, 3, 2, 1, 2, 3, 1'b0, 0);
        total++; if (o_gnt !== 4'b0100 || o_dtb !== 2'b10) begin bad++;
            $display("FAIL drop_gnt: got %b dtb %b exp 0100 dtb 10", o_gnt, o_dtb); end
        total++; if (o_done !== 4'b0100 || o_done_n !== 1 || o_done_c !== e.done_c || o_hung) begin bad++;
            $display("FAIL drop_done: got %b x%0d @%0d hung=%0d exp 0100 x1 @%0d", o_done, o_done_n, o_done_c, o_hung, e.done_c); end
        m_ptr = 3;
    endtask

    task automatic test_zero_delay;
        exp_t e;
        int ei;
        setup_i = 4'd0; hold_i = 4'd0; gap_i = 4'd0; dtb_i = 8'h55;
        req_i = 4'b1010;
        ei = m_pick(4'b1010);
        observe_txn(1, 1, 1'b0, 1'b1);
        e = m_txn(o_t0, 0, 0, 0, 1, 1, 1'b0, 0);
        total++; if (o_st_c !== e.st_c) begin bad++; $display("FAIL zero_st: got @%0d exp @%0d", o_st_c, e.st_c); end
        total++; if (o_setup_len !== 1 || o_hold_len !== 1 || o_gap_len !== 1) begin bad++;
            $display("FAIL zero_lens: got setup=%0d hold=%0d gap=%0d exp 1 1 1", o_setup_len, o_hold_len, o_gap_len); end
        total++; if (o_gnt !== N'(1 << ei) || o_idle_c !== e.idle_c) begin bad++;
            $display("FAIL zero_txn: got %b idle@%0d exp %b idle@%0d", o_gnt, o_idle_c, N'(1 << ei), e.idle_c); end
        m_ptr = (ei + 1) % N;
    endtask

`ifdef SPI_SCHED_TIMEOUT_EN
    task automatic test_timeout;
        exp_t e;
        int ei;
        setup_i = 4'd1; hold_i = 4'd1; gap_i = 4'd0; tmo_i = 16'd20; dtb_i = 8'h00;
        req_i = 4'b0001;
        ei = m_pick(4'b0001);
        observe_txn(1, 0, 1'b1, 1'b1);
        e = m_txn(o_t0, 1, 1, 0, 1, 0, 1'b1, 20);
        total++; if (o_err_c !== e.err_c || o_err_n !== 1) begin bad++;
            $display("FAIL timeout_err: got @%0d x%0d exp @%0d x1", o_err_c, o_err_n, e.err_c); end
        total++; if (o_done !== N'(1 << ei) || o_done_c !== e.done_c) begin bad++;
            $display("FAIL timeout_done: got %b @%0d exp %b @%0d", o_done, o_done_c, N'(1 << ei), e.done_c); end
        m_ptr = (ei + 1) % N;
        tmo_i = '1;
    endtask
`endif

    task automatic test_random;
        exp_t e;
        int ei, s, h, g, d, l;
        logic [N-1:0]   r;
        logic [2*N-1:0] sv_dtb;
        for (int k = 0; k < 12; k++) begin
            r = N'($urandom_range(1, 15));
            sv_dtb = 8'($urandom);
            s = $urandom_range(0, 15); h = $urandom_range(0, 15); g = $urandom_range(0, 15);
            d = $urandom_range(1, 3);  l = $urandom_range(1, 6);
            dtb_i = sv_dtb; setup_i = 4'(s); hold_i = 4'(h); gap_i = 4'(g);
            req_i = r;
            ei = m_pick(r);
            observe_txn(d, l, 1'b0, 1'b1);
            e = m_txn(o_t0, s, h, g, d, l, 1'b0, 0);
            total++; if (o_gnt !== N'(1 << ei) || o_dtb !== sv_dtb[2*ei +: 2]) begin bad++;
                $display("FAIL rand%0d_gnt: got %b dtb %b exp %b dtb %b", k, o_gnt, o_dtb, N'(1 << ei), sv_dtb[2*ei +: 2]); end
            total++; if (o_st_c !== e.st_c || o_done_c !== e.done_c || o_idle_c !== e.idle_c) begin bad++;
                $display("FAIL rand%0d_timing: got st@%0d done@%0d idle@%0d exp st@%0d done@%0d idle@%0d",
                         k, o_st_c, o_done_c, o_idle_c, e.st_c, e.done_c, e.idle_c); end
            total++; if (o_nss_low !== e.nss_low || o_done !== N'(1 << ei) || o_err_n !== 0) begin bad++;
                $display("FAIL rand%0d_cs: got nss_low=%0d done=%b err=%0d exp %0d %b 0",
                         k, o_nss_low, o_done, o_err_n, e.nss_low, N'(1 << ei)); end
            m_ptr = (ei + 1) % N;
        end
    endtask

    task automatic test_reset_mid;
        int ei;
        bit reached;
        setup_i = 4'd1; hold_i = 4'd1; gap_i = 4'd1; dtb_i = 8'h00;
        req_i = 4'b0010;
        ei = m_pick(4'b0010);
        observe_txn(1, 2, 1'b0, 1'b1);
        m_ptr = (ei + 1) % N;
        setup_i = 4'd1; hold_i = 4'd1; gap_i = 4'd1;
        req_i = 4'b1111;
        ei = m_pick(4'b1111);
        reached = 0;
        for (int k = 0; k < 40 && !reached; k++) begin
            @(negedge clk);
            if (dbg_state_o == ST_XFER) reached = 1;
        end
        total++; if (!reached || gnt_o !== N'(1 << ei)) begin bad++;
            $display("FAIL rstmid_pre: reached=%0d gnt=%b exp 1 %b", reached, gnt_o, N'(1 << ei)); end
        core_busy_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0; core_busy_i = 1'b0;
        m_ptr = 0;
        total++; if (nss_o !== '1 || gnt_o !== '0 || busy_o !== 1'b0) begin bad++;
            $display("FAIL rstmid_out: nss=%b gnt=%b busy=%b exp 1111 0000 0", nss_o, gnt_o, busy_o); end
        ei = m_pick(4'b1111);
        observe_txn(1, 2, 1'b0, 1'b1);
        total++; if (o_gnt !== N'(1 << ei) || o_gnt_c !== o_t0 + 1) begin bad++;
            $display("FAIL rstmid_next: got %b@%0d exp %b@%0d", o_gnt, o_gnt_c, N'(1 << ei), o_t0 + 1); end
        m_ptr = (ei + 1) % N;
    endtask

    initial begin
        test_reset;
        test_contention;
        test_single;
        test_drop;
        test_zero_delay;
`ifdef SPI_SCHED_TIMEOUT_EN
        test_timeout;
`endif
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
